// File: rtl/decoder_scan_n_pkg.sv
// Shared definitions for the scanning decoder slice.
//   mode_e        : direct decode versus auto-scan selection.
//   pick_t        : result of the masked-channel search (found flag + index).
//   clog2()       : ceiling log2, used to size the prescaler counter.
//   next_unmasked : nearest enabled channel above idx, wrapping from n-1 to 0.
// The search works on fixed MAX_SEL_W / MAX_N wide vectors so one function can
// serve any SEL_W up to MAX_SEL_W; callers zero-extend their index and mask.
package decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int MAX_SEL_W = 6;
  localparam int MAX_N     = 1 << MAX_SEL_W;

  typedef struct packed {
    logic                 found;
    logic [MAX_SEL_W-1:0] idx;
  } pick_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Candidates are visited from the farthest (idx itself) to the nearest
  // (idx+1), so the nearest unmasked channel is the one left in r.
  function automatic pick_t next_unmasked(input logic [MAX_SEL_W-1:0] idx,
                                          input logic [MAX_N-1:0]     mask,
                                          input int                   n);
    pick_t r;
    int    cand;
    r = '0;
    for (int k = MAX_N; k >= 1; k--) begin
      if (k <= n) begin
        cand = (int'(idx) + k) % n;
        if (!mask[cand[MAX_SEL_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = cand[MAX_SEL_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_scan_n_if.sv
// Control/result bundle of decoder_scan_n.
//   en, mode, x, mask : driven by the controller (master).
//   y, sel_out, step  : driven by the decoder (slave).
interface decoder_scan_n_if #(
  parameter int SEL_W = 2
);
  localparam int N = 1 << SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] x;
  logic [N-1:0]     mask;
  logic [N-1:0]     y;
  logic [SEL_W-1:0] sel_out;
  logic             step;

  modport master (
    output en, mode, x, mask,
    input  y, sel_out, step
  );

  modport slave (
    input  en, mode, x, mask,
    output y, sel_out, step
  );

endinterface

// File: rtl/decoder_scan_n_tick_gen.sv
// Scan prescaler: counts 0..PRESCALE-1 while run is high and flags the last
// count with a combinational tick, then wraps. clr forces the count to 0 and
// suppresses the tick; it has priority over run.
//   clk, rst_n : clock, asynchronous active-low reset.
//   run        : advance the count (freezes it when low).
//   clr        : synchronous clear.
//   tick       : high in the cycle the count equals PRESCALE-1.
module tick_gen
  import decoder_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int            CW_RAW = clog2(PRESCALE);
  localparam int            CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] LAST   = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered SEL_W-to-2^SEL_W decoder with masked auto-scan.
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus.en     : output enable; low blanks y and freezes scanning.
//   bus.mode   : MODE_DIRECT decodes x, MODE_SCAN walks unmasked channels.
//   bus.x      : channel select in direct mode.
//   bus.mask   : 1 disables a channel in both modes.
//   bus.y      : one-hot (or all inactive) output; channel i drives y[N-1-i].
//   bus.sel_out: registered current channel index.
//   bus.step   : one-cycle pulse when the scan index actually changes.
// SEL_W must not exceed decoder_pkg::MAX_SEL_W.
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int PRESCALE   = 50000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  decoder_scan_n_if.slave bus
);

  localparam int           N      = 1 << SEL_W;
  localparam logic [N-1:0] Y_IDLE = {N{ACTIVE_LOW}};

  mode_e                mode_in, mode_q, mode_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [N-1:0]         y_q, y_d;
  logic                 step_q, step_d;
  logic                 tick, clr, run;
  logic [MAX_SEL_W-1:0] idx_ext;
  logic [MAX_N-1:0]     mask_ext;
  logic [SEL_W-1:0]     rev_idx;
  pick_t                pick;

  // The prescaler sits at 0 in direct mode and restarts on any mode change.
  assign mode_in = mode_e'(bus.mode);
  assign clr     = (mode_in == MODE_DIRECT) || (mode_in != mode_q);
  assign run     = bus.en;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    mode_d   = mode_in;
    sel_d    = sel_q;
    step_d   = 1'b0;
    y_d      = Y_IDLE;
    idx_ext  = '0;
    mask_ext = '0;
    idx_ext[SEL_W-1:0] = sel_q;
    mask_ext[N-1:0]    = bus.mask;
    pick     = next_unmasked(idx_ext, mask_ext, N);

    // With en low the index holds in both modes.
    if (bus.en) begin
      if (mode_in == MODE_DIRECT) begin
        sel_d = bus.x;
      end else if (tick && pick.found) begin
        sel_d  = pick.idx[SEL_W-1:0];
        step_d = (pick.idx != idx_ext);
      end
    end

    // N-1-i equals the bitwise inverse of i because N is a power of two.
    rev_idx = ~sel_d;
    if (bus.en && !bus.mask[sel_d]) begin
      y_d[rev_idx] = ~ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_DIRECT;
      sel_q  <= '0;
      y_q    <= Y_IDLE;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      sel_q  <= sel_d;
      y_q    <= y_d;
      step_q <= step_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.sel_out = sel_q;
  assign bus.step    = step_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n (SEL_W=2, PRESCALE=4), plus an ACTIVE_LOW
// instance used for the polarity checks.
module tb_decoder_scan_n;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decoder_scan_n_if #(.SEL_W(2)) bus ();
  decoder_scan_n_if #(.SEL_W(2)) bus_al ();

  decoder_scan_n #(
    .SEL_W(2), .PRESCALE(4), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  decoder_scan_n #(
    .SEL_W(2), .PRESCALE(4), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_al.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] ey,
                          input logic [1:0] es, input logic est);
    checkOutput({tag, ".y"},       32'(bus.y),       32'(ey));
    checkOutput({tag, ".sel_out"}, 32'(bus.sel_out), 32'(es));
    checkOutput({tag, ".step"},    32'(bus.step),    32'(est));
  endtask

  task automatic applyStimulus(input logic e, input logic m,
                               input logic [1:0] xv, input logic [3:0] mk);
    bus.en   = e;
    bus.mode = m;
    bus.x    = xv;
    bus.mask = mk;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Three quiet cycles holding the old channel, then the advance edge.
  task automatic scanAdvance(input string tag,
                             input logic [3:0] old_y, input logic [1:0] old_sel,
                             input logic [3:0] new_y, input logic [1:0] new_sel);
    cycles(3);
    checkAll({tag, "_hold"}, old_y, old_sel, 1'b0);
    cycles(1);
    checkAll({tag, "_adv"}, new_y, new_sel, 1'b1);
  endtask

  initial begin
    logic [3:0] dexp [4];
    dexp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    applyStimulus(1'b1, 1'b0, 2'd0, 4'b0000);
    bus_al.en   = 1'b1;
    bus_al.mode = 1'b0;
    bus_al.x    = 2'd1;
    bus_al.mask = 4'b0000;

    #2 rst_n = 1'b0;
    #10;
    checkAll("reset", 4'b0000, 2'd0, 1'b0);
    checkOutput("al_reset.y", 32'(bus_al.y), 32'hF);
    cycles(1);
    rst_n = 1'b1;

    // Direct decode of every select value
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 2'(i), 4'b0000);
      cycles(1);
      checkAll($sformatf("direct_x%0d", i), dexp[i], 2'(i), 1'b0);
    end
    checkOutput("al_direct.y", 32'(bus_al.y), 32'hB);

    applyStimulus(1'b0, 1'b0, 2'd3, 4'b0000);
    bus_al.en = 1'b0;
    cycles(1);
    checkOutput("direct_en0.y", 32'(bus.y), 32'h0);
    checkOutput("al_en0.y", 32'(bus_al.y), 32'hF);

    applyStimulus(1'b1, 1'b0, 2'd0, 4'b0000);
    cycles(1);
    checkAll("direct_back", 4'b1000, 2'd0, 1'b0);

    // Full scan wrap
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b0000);
    cycles(1);
    checkAll("scan_start", 4'b1000, 2'd0, 1'b0);
    scanAdvance("scan01", 4'b1000, 2'd0, 4'b0100, 2'd1);
    scanAdvance("scan12", 4'b0100, 2'd1, 4'b0010, 2'd2);
    scanAdvance("scan23", 4'b0010, 2'd2, 4'b0001, 2'd3);
    scanAdvance("scan30", 4'b0001, 2'd3, 4'b1000, 2'd0);

    // Channels 1 and 2 masked
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b0110);
    scanAdvance("skip03", 4'b1000, 2'd0, 4'b0001, 2'd3);
    scanAdvance("skip30", 4'b0001, 2'd3, 4'b1000, 2'd0);

    // Everything masked: one tick falls inside these five cycles
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      checkAll($sformatf("allmask%0d", i), 4'b0000, 2'd0, 1'b0);
    end

    // Only the current channel enabled
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b1110);
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      checkAll($sformatf("single%0d", i), 4'b1000, 2'd0, 1'b0);
    end

    // Current channel masked mid-count, channel 1 reopened
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b1101);
    cycles(1);
    checkAll("midmask_off", 4'b0000, 2'd0, 1'b0);
    cycles(1);
    checkAll("midmask_wait", 4'b0000, 2'd0, 1'b0);
    cycles(1);
    checkAll("midmask_adv", 4'b0100, 2'd1, 1'b1);

    // Freeze with en low at prescaler count 2
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b0000);
    cycles(2);
    checkAll("pre_freeze", 4'b0100, 2'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b0000);
    cycles(10);
    checkAll("frozen", 4'b0000, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b0000);
    cycles(1);
    checkAll("resume", 4'b0100, 2'd1, 1'b0);
    cycles(1);
    checkAll("resume_tick", 4'b0010, 2'd2, 1'b1);
    scanAdvance("to3", 4'b0010, 2'd2, 4'b0001, 2'd3);

    // Mode changes
    applyStimulus(1'b1, 1'b0, 2'd2, 4'b0000);
    cycles(1);
    checkAll("scan2direct", 4'b0010, 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd2, 4'b0000);
    cycles(1);
    checkAll("direct2scan", 4'b0010, 2'd2, 1'b0);
    scanAdvance("rescan", 4'b0010, 2'd2, 4'b0001, 2'd3);

    // Reset while a step pulse is showing
    #2 rst_n = 1'b0;
    #1;
    checkAll("reset_mid", 4'b0000, 2'd0, 1'b0);
    checkOutput("al_reset_mid.y", 32'(bus_al.y), 32'hF);
    cycles(1);
    rst_n = 1'b1;
    cycles(1);
    checkAll("post_reset", 4'b1000, 2'd0, 1'b0);
    scanAdvance("post_reset", 4'b1000, 2'd0, 4'b0100, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
